sipo: RTL

SIPO -- requirements
Module: sipo

---
 rtl/sipo.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sipo.sv
`default_nettype none
// ============================================================================
// Module   : sipo
// Brief    : Serial-in parallel-out receiver, LSB first, with idle-gap timeout.
//            Optional even-parity bit enabled by macro SIPO_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sipo #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] c_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] c_TO   = GW'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef SIPO_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif

    logic [1:0]            r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [GW-1:0]         r_gap, w_gap_nxt, w_gap_inc;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_ins;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_ferr, w_ferr_nxt;
    logic                  r_perr, w_perr_nxt;

    // Shift register with the incoming bit dropped into position r_cnt.
    always_comb begin
        w_ins = r_shift;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r_cnt == CW'(i)) w_ins[i] = data_in;
        end
    end

    assign w_gap_inc = r_gap + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_perr_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_gap_nxt = '0;
                if (valid_in) begin
                    w_shift_nxt = {{(DATA_WIDTH-1){1'b0}}, data_in};
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (valid_in) begin
                    w_gap_nxt   = '0;
                    w_shift_nxt = w_ins;
                    if (r_cnt == c_LAST) begin
`ifdef SIPO_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_data_nxt  = w_ins;
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (w_gap_inc == c_TO) begin
                    w_ferr_nxt  = 1'b1;
                    w_gap_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = w_gap_inc;
                end
            end
`ifdef SIPO_PARITY_EN
            S_PARITY: begin
                if (valid_in) begin
                    w_data_nxt  = r_shift;
                    w_valid_nxt = 1'b1;
                    w_perr_nxt  = (^r_shift) ^ data_in;
                    w_gap_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (w_gap_inc == c_TO) begin
                    w_ferr_nxt  = 1'b1;
                    w_gap_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = w_gap_inc;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_gap_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_perr  <= w_perr_nxt;
        end
    end

    assign data_out   = r_data;
    assign valid_out  = r_valid;
    assign busy       = (r_state != S_IDLE);
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;

endmodule
`default_nettype wire
